apb_uart_csr: RTL and testbench
===============================

APB_UART_CSR -- requirements
Module: apb_uart_csr

Interface
REQ-001 SHALL have parameters (name, default, meaning): ADDR_WIDTH, 4, APB register-index width; DATA_WIDTH, 16, bus width (16 or 32); WAIT_STATES, 0, access-phase wait cycles (0..15); FIFO_AW, 4, external FIFO address width (levels are FIFO_AW+1 bits, FIFO_AW<=7); BAUD_RESET, 16'd27, reset baud divisor.
REQ-002 SHALL have ports (name, direction, width, meaning); one clock; reset is synchronous and active-high:
- clk, in, 1, sole clock, all logic on its rising edge
- rst, in, 1, synchronous active-high reset
- PADDR, in, ADDR_WIDTH, register index
- PSELx / PENABLE / PWRITE, in, 1 each, APB select / access phase / write
- PWDATA, in, DATA_WIDTH, write data
- PREADY, out, 1, transfer complete
- PRDATA, out, DATA_WIDTH, read data
- PSLVERR, out, 1, transfer error
- tx_push, out, 1, TX FIFO write strobe; tx_data, out, 8, pushed byte
- tx_full / tx_busy, in, 1 each, TX FIFO full / serialiser active; tx_level, in, FIFO_AW+1, TX occupancy
- rx_pop, out, 1, RX FIFO read strobe; rx_data, in, 8, show-ahead RX head
- rx_empty, in, 1, RX FIFO empty; rx_level, in, FIFO_AW+1, RX occupancy
- rx_frame_err / rx_overrun, in, 1 each, single-cycle error events
- uart_en, out, 1; data_bits, out, 2 (0..3 = 5..8 bits); parity, out, 2 (0 none, 1 odd, 2 even); stop2, out, 1; baud_div, out, 16
- irq, out, 1, registered level interrupt

Function
REQ-003 SHALL decode registers: 0 DATA (W push / R pop), 1 STATUS RO {bit2 rx_empty, bit1 tx_full, bit0 tx_busy}, 2 CTRL RW {bit5 stop2, bits4:3 parity, bits2:1 data_bits, bit0 uart_en}, 3 BAUD RW, 4 IRQ_EN RW bits3:0, 5 LEVEL RO {15:8 rx_level, 7:0 tx_level}, 6 IRQ_STAT, 7 THRESH RW {15:8 tx_thresh, 7:0 rx_thresh}; bits above 15 read 0.
REQ-004 SHALL, for setup cycle T0 (PSELx=1, PENABLE=0) and first access cycle T1, drive PREADY=1 only in cycle T1+WAIT_STATES, PREADY=0 otherwise; PREADY, PRDATA, PSLVERR registered.
REQ-005 SHALL apply side effects (register write, tx_push, rx_pop, W1C) only in the cycle where PSELx&PENABLE&PREADY; tx_push/rx_pop are one-cycle pulses there.
REQ-006 SHALL drive PRDATA=0 and PSLVERR=0 whenever PREADY=0.
REQ-007 SHALL abort without side effects and return to IDLE if PSELx drops before PREADY.
REQ-008 SHALL assert PSLVERR with no side effect for: unmapped index (>7 when ADDR_WIDTH>3), write to STATUS/LEVEL, DATA write while tx_full, DATA read while rx_empty (PRDATA=0), BAUD write of 0, CTRL write with parity=3.
REQ-009 SHALL use a phase FSM IDLE -> WAIT (counter loaded with WAIT_STATES at T0) -> DONE (PREADY cycle) -> IDLE; WAIT_STATES=0 goes IDLE -> DONE directly.
REQ-010 IRQ_STAT SHALL hold bit0 rx_avail = (rx_level >= rx_thresh) and bit1 tx_low = (tx_level <= tx_thresh), both live, plus bit2 frame_err and bit3 overrun, both sticky.
REQ-011 Writing 1 to IRQ_STAT bits 3:2 SHALL clear them; live bits SHALL ignore writes; a set event in the same cycle as a clear SHALL win.
REQ-012 irq SHALL equal the OR of (IRQ_STAT & IRQ_EN), registered, so it has one cycle of latency.
REQ-013 Threshold and level compares SHALL be unsigned, zero-extended to 8 bits.

Reset
REQ-014 On rst: FSM=IDLE, PREADY=0, PRDATA=0, PSLVERR=0, tx_push=0, rx_pop=0, irq=0, CTRL=0x0006 (uart_en=0, 8 bits, no parity, 1 stop), baud_div=BAUD_RESET, IRQ_EN=0, sticky bits=0, rx_thresh=1, tx_thresh=0.
REQ-015 rst asserted mid-transfer SHALL cancel the transfer with no side effect.

Structure
REQ-016 Package apb_uart_pkg SHALL hold register indices, CTRL field positions, the phase-FSM state type, and reset values.
REQ-017 The phase FSM and wait counter SHALL be sub-module apb_wait_ctrl; decode, registers and interrupts stay in apb_uart_csr.

Verification
REQ-018 WAIT_STATES=0: write 0x0041 to DATA with tx_full=0 -> PREADY in T1, one tx_push pulse, tx_data=0x41, PSLVERR=0.
REQ-019 WAIT_STATES=3: read CTRL after reset -> PREADY only in T1+3, PRDATA=0x0006.
REQ-020 rx_empty=1, read DATA -> PSLVERR=1, PRDATA=0, no rx_pop; with rx_empty=0, rx_data=0x5A -> PRDATA=0x005A and one rx_pop.
REQ-021 Write BAUD=0 -> PSLVERR=1 and baud_div unchanged at 27; write BAUD=54 -> baud_div=54.
REQ-022 IRQ_EN=0x4, rx_frame_err pulse -> irq=1 one cycle later; write IRQ_STAT=0x4 in the same cycle as a second rx_frame_err pulse -> bit2 stays 1.

Source files
------------

// File: rtl/apb_uart_pkg.sv
// Shared constants and types for the APB UART control/status register block.
package apb_uart_pkg;

  localparam int unsigned REG_IDX_W = 3;

  localparam logic [REG_IDX_W-1:0] REG_DATA     = 3'd0;
  localparam logic [REG_IDX_W-1:0] REG_STATUS   = 3'd1;
  localparam logic [REG_IDX_W-1:0] REG_CTRL     = 3'd2;
  localparam logic [REG_IDX_W-1:0] REG_BAUD     = 3'd3;
  localparam logic [REG_IDX_W-1:0] REG_IRQ_EN   = 3'd4;
  localparam logic [REG_IDX_W-1:0] REG_LEVEL    = 3'd5;
  localparam logic [REG_IDX_W-1:0] REG_IRQ_STAT = 3'd6;
  localparam logic [REG_IDX_W-1:0] REG_THRESH   = 3'd7;

  localparam int unsigned CTRL_W         = 6;
  localparam int unsigned CTRL_EN_BIT    = 0;
  localparam int unsigned CTRL_DB_LSB    = 1;
  localparam int unsigned CTRL_PAR_LSB   = 3;
  localparam int unsigned CTRL_STOP2_BIT = 5;

  localparam logic [CTRL_W-1:0] CTRL_RESET      = 6'h06;
  localparam logic [15:0]       BAUD_RESET_DEF  = 16'd27;
  localparam logic [3:0]        IRQ_EN_RESET    = 4'h0;
  localparam logic [7:0]        RX_THRESH_RESET = 8'd1;
  localparam logic [7:0]        TX_THRESH_RESET = 8'd0;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_WAIT = 2'd1,
    PH_DONE = 2'd2
  } phase_e;

endpackage

// File: rtl/apb_uart_csr_if.sv
// APB slave bus bundle for the UART CSR block.
interface apb_uart_csr_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 16
) ();
  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PSELx;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic                  PREADY;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PSLVERR;

  modport master (output PADDR, PSELx, PENABLE, PWRITE, PWDATA,
                  input  PREADY, PRDATA, PSLVERR);
  modport slave  (input  PADDR, PSELx, PENABLE, PWRITE, PWDATA,
                  output PREADY, PRDATA, PSLVERR);
endinterface

// File: rtl/apb_wait_ctrl.sv
// APB transfer phase tracker: inserts WAIT_STATES access cycles, then one PREADY cycle.
module apb_wait_ctrl
  import apb_uart_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic psel,
  input  logic penable,
  output logic pready,
  output logic done_nxt_c
);
  localparam int unsigned CW = 4;

  phase_e        state, state_n;
  logic [CW-1:0] cnt, cnt_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= PH_IDLE;
      cnt    <= '0;
      pready <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      pready <= (state_n == PH_DONE);
    end
  end

  // Dropping PSELx before completion falls back to IDLE, which cancels the transfer.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      PH_IDLE: begin
        if (psel && !penable) begin
          if (WAIT_STATES == 0) begin
            state_n = PH_DONE;
          end else begin
            state_n = PH_WAIT;
            cnt_n   = CW'(WAIT_STATES);
          end
        end
      end
      PH_WAIT: begin
        if (!psel)                  state_n = PH_IDLE;
        else if (cnt <= CW'(1))     state_n = PH_DONE;
        else                        cnt_n   = cnt - CW'(1);
      end
      PH_DONE: state_n = PH_IDLE;
      default: state_n = PH_IDLE;
    endcase
  end

  assign done_nxt_c = (state_n == PH_DONE);

endmodule

// File: rtl/apb_uart_csr.sv
// UART control/status registers behind an APB slave: decode, FIFO strobes, config and interrupts.
module apb_uart_csr
  import apb_uart_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned FIFO_AW     = 4,
  parameter logic [15:0] BAUD_RESET  = BAUD_RESET_DEF
) (
  input  logic               clk,
  input  logic               rst,
  apb_uart_csr_if.slave      apb,
  output logic               tx_push,
  output logic [7:0]         tx_data,
  input  logic               tx_full,
  input  logic               tx_busy,
  input  logic [FIFO_AW:0]   tx_level,
  output logic               rx_pop,
  input  logic [7:0]         rx_data,
  input  logic               rx_empty,
  input  logic [FIFO_AW:0]   rx_level,
  input  logic               rx_frame_err,
  input  logic               rx_overrun,
  output logic               uart_en,
  output logic [1:0]         data_bits,
  output logic [1:0]         parity,
  output logic               stop2,
  output logic [15:0]        baud_div,
  output logic               irq
);
  logic                 go_done_c;
  logic [REG_IDX_W-1:0] idx;
  logic                 mapped;
  logic [15:0]          wd;
  logic [15:0]          rdata_c;
  logic                 err_c;
  logic                 wr_commit;
  logic                 stat_clr;
  logic [CTRL_W-1:0]    ctrl;
  logic [3:0]           irq_en;
  logic [7:0]           rx_thresh, tx_thresh;
  logic                 frame_st, overrun_st;
  logic [3:0]           irq_stat_c;

  apb_wait_ctrl #(.WAIT_STATES(WAIT_STATES)) u_wait (
    .clk        (clk),
    .rst        (rst),
    .psel       (apb.PSELx),
    .penable    (apb.PENABLE),
    .pready     (apb.PREADY),
    .done_nxt_c (go_done_c)
  );

  assign idx    = REG_IDX_W'(apb.PADDR);
  assign mapped = (32'(apb.PADDR) <= 32'd7);
  assign wd     = 16'(apb.PWDATA);

  assign irq_stat_c = {overrun_st, frame_st,
                       (8'(tx_level) <= tx_thresh),
                       (8'(rx_level) >= rx_thresh)};

  // Read mux.
  always_comb begin
    rdata_c = '0;
    case (idx)
      REG_DATA:     rdata_c = {8'h00, rx_data};
      REG_STATUS:   rdata_c = {13'd0, rx_empty, tx_full, tx_busy};
      REG_CTRL:     rdata_c = {10'd0, ctrl};
      REG_BAUD:     rdata_c = baud_div;
      REG_IRQ_EN:   rdata_c = {12'd0, irq_en};
      REG_LEVEL:    rdata_c = {8'(rx_level), 8'(tx_level)};
      REG_IRQ_STAT: rdata_c = {12'd0, irq_stat_c};
      REG_THRESH:   rdata_c = {tx_thresh, rx_thresh};
      default:      rdata_c = '0;
    endcase
  end

  // Error classification, evaluated as the transfer enters its PREADY cycle.
  always_comb begin
    err_c = 1'b0;
    if (!mapped) begin
      err_c = 1'b1;
    end else if (apb.PWRITE) begin
      case (idx)
        REG_STATUS, REG_LEVEL: err_c = 1'b1;
        REG_DATA:              err_c = tx_full;
        REG_BAUD:              err_c = (wd == 16'd0);
        REG_CTRL:              err_c = (wd[CTRL_PAR_LSB +: 2] == 2'd3);
        default:               err_c = 1'b0;
      endcase
    end else if (idx == REG_DATA) begin
      err_c = rx_empty;
    end
  end

  // Bus response and FIFO strobes are staged so they land exactly in the PREADY cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      apb.PRDATA  <= '0;
      apb.PSLVERR <= 1'b0;
      tx_push     <= 1'b0;
      tx_data     <= 8'h00;
      rx_pop      <= 1'b0;
    end else begin
      apb.PRDATA  <= '0;
      apb.PSLVERR <= 1'b0;
      tx_push     <= 1'b0;
      rx_pop      <= 1'b0;
      if (go_done_c) begin
        apb.PSLVERR <= err_c;
        if (!apb.PWRITE && !err_c) apb.PRDATA <= DATA_WIDTH'(rdata_c);
        if (apb.PWRITE && !err_c && idx == REG_DATA) begin
          tx_push <= 1'b1;
          tx_data <= wd[7:0];
        end
        if (!apb.PWRITE && !err_c && idx == REG_DATA) rx_pop <= 1'b1;
      end
    end
  end

  assign wr_commit = apb.PSELx & apb.PENABLE & apb.PREADY & apb.PWRITE & ~apb.PSLVERR;
  assign stat_clr  = wr_commit & (idx == REG_IRQ_STAT);

  // Config registers; sticky error bits let a new event win over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl       <= CTRL_RESET;
      baud_div   <= BAUD_RESET;
      irq_en     <= IRQ_EN_RESET;
      rx_thresh  <= RX_THRESH_RESET;
      tx_thresh  <= TX_THRESH_RESET;
      frame_st   <= 1'b0;
      overrun_st <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (wr_commit) begin
        case (idx)
          REG_CTRL:   ctrl     <= wd[CTRL_W-1:0];
          REG_BAUD:   baud_div <= wd;
          REG_IRQ_EN: irq_en   <= wd[3:0];
          REG_THRESH: begin
            rx_thresh <= wd[7:0];
            tx_thresh <= wd[15:8];
          end
          default: ;
        endcase
      end
      frame_st   <= rx_frame_err | (frame_st   & ~(stat_clr & wd[2]));
      overrun_st <= rx_overrun   | (overrun_st & ~(stat_clr & wd[3]));
      irq        <= |(irq_stat_c & irq_en);
    end
  end

  assign uart_en   = ctrl[CTRL_EN_BIT];
  assign data_bits = ctrl[CTRL_DB_LSB +: 2];
  assign parity    = ctrl[CTRL_PAR_LSB +: 2];
  assign stop2     = ctrl[CTRL_STOP2_BIT];

endmodule

// File: tb/tb_apb_uart_csr.sv
// Randomized bench for apb_uart_csr: two instances (0 and 3 wait states) against a register-level model.
module tb_apb_uart_csr;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       tx_full = 1'b0, tx_busy = 1'b0, rx_empty = 1'b1;
  logic       rx_frame_err = 1'b0, rx_overrun = 1'b0;
  logic [4:0] tx_level = '0, rx_level = '0;
  logic [7:0] rx_data = '0;

  logic        tx_push_w[2];
  logic [7:0]  tx_data_w[2];
  logic        rx_pop_w[2];
  logic        uart_en_w[2];
  logic [1:0]  data_bits_w[2];
  logic [1:0]  parity_w[2];
  logic        stop2_w[2];
  logic [15:0] baud_w[2];
  logic        irq_w[2];

  apb_uart_csr_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) bus_a ();
  apb_uart_csr_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) bus_b ();

  apb_uart_csr #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .WAIT_STATES(0), .FIFO_AW(4), .BAUD_RESET(16'd27)) u_dut_a (
    .clk(clk), .rst(rst), .apb(bus_a),
    .tx_push(tx_push_w[0]), .tx_data(tx_data_w[0]), .tx_full(tx_full), .tx_busy(tx_busy), .tx_level(tx_level),
    .rx_pop(rx_pop_w[0]), .rx_data(rx_data), .rx_empty(rx_empty), .rx_level(rx_level),
    .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun),
    .uart_en(uart_en_w[0]), .data_bits(data_bits_w[0]), .parity(parity_w[0]), .stop2(stop2_w[0]),
    .baud_div(baud_w[0]), .irq(irq_w[0]));

  apb_uart_csr #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .WAIT_STATES(3), .FIFO_AW(4), .BAUD_RESET(16'd27)) u_dut_b (
    .clk(clk), .rst(rst), .apb(bus_b),
    .tx_push(tx_push_w[1]), .tx_data(tx_data_w[1]), .tx_full(tx_full), .tx_busy(tx_busy), .tx_level(tx_level),
    .rx_pop(rx_pop_w[1]), .rx_data(rx_data), .rx_empty(rx_empty), .rx_level(rx_level),
    .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun),
    .uart_en(uart_en_w[1]), .data_bits(data_bits_w[1]), .parity(parity_w[1]), .stop2(stop2_w[1]),
    .baud_div(baud_w[1]), .irq(irq_w[1]));

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Register-level model, one copy per instance.
  logic [5:0]  ctrl_m[2];
  logic [15:0] baud_m[2];
  logic [3:0]  ien_m[2];
  logic [7:0]  rxth_m[2], txth_m[2];
  logic        fe_m[2], ov_m[2];
  logic [15:0] last_rd;
  logic        last_err;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      ctrl_m[i] = 6'h06; baud_m[i] = 16'd27; ien_m[i] = 4'h0;
      rxth_m[i] = 8'd1;  txth_m[i] = 8'd0;   fe_m[i] = 1'b0; ov_m[i] = 1'b0;
    end
  endtask

  function automatic logic [3:0] stat_m(int d);
    logic rx_av, tx_lo;
    rx_av = int'(rx_level) >= int'(rxth_m[d]);
    tx_lo = int'(tx_level) <= int'(txth_m[d]);
    return {ov_m[d], fe_m[d], tx_lo, rx_av};
  endfunction

  function automatic logic rdy(int d);
    return (d != 0) ? bus_b.PREADY : bus_a.PREADY;
  endfunction
  function automatic logic [15:0] prd(int d);
    return (d != 0) ? bus_b.PRDATA : bus_a.PRDATA;
  endfunction
  function automatic logic perr(int d);
    return (d != 0) ? bus_b.PSLVERR : bus_a.PSLVERR;
  endfunction

  task automatic set_bus(input int d, input logic sel, input logic en, input logic wr,
                         input logic [3:0] a, input logic [15:0] wd);
    bus_a.PSELx = sel && (d == 0);  bus_b.PSELx = sel && (d != 0);
    bus_a.PENABLE = en;   bus_b.PENABLE = en;
    bus_a.PWRITE  = wr;   bus_b.PWRITE  = wr;
    bus_a.PADDR   = a;    bus_b.PADDR   = a;
    bus_a.PWDATA  = wd;   bus_b.PWDATA  = wd;
  endtask

  // One APB transfer; observes latency, strobes and idle-cycle response cleanliness.
  task automatic xfer(input int d, input logic wr, input logic [3:0] a, input logic [15:0] wd,
                      input bit fe_done, output logic [15:0] rd, output logic er, output int lat,
                      output int pu, output int po, output logic [7:0] txd, output int viol);
    bit done = 0;
    rd = '0; er = 1'b0; lat = 0; pu = 0; po = 0; txd = '0; viol = 0;
    @(posedge clk); #1;
    set_bus(d, 1'b1, 1'b0, wr, a, wd);
    @(negedge clk);
    if (rdy(d) || prd(d) != 16'd0 || perr(d)) viol++;
    if (tx_push_w[d]) pu++;
    if (rx_pop_w[d]) po++;
    @(posedge clk); #1;
    set_bus(d, 1'b1, 1'b1, wr, a, wd);
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (tx_push_w[d]) begin pu++; txd = tx_data_w[d]; end
      if (rx_pop_w[d]) po++;
      if (rdy(d)) begin
        rd = prd(d); er = perr(d); done = 1;
        if (fe_done) rx_frame_err = 1'b1;
      end else begin
        if (prd(d) != 16'd0 || perr(d)) viol++;
        lat++;
      end
      @(posedge clk); #1;
      if (fe_done) rx_frame_err = 1'b0;
    end
    set_bus(d, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0);
    @(negedge clk);
    if (tx_push_w[d]) pu++;
    if (rx_pop_w[d]) po++;
    if (rdy(d)) viol++;
  endtask

  task automatic run(input int d, input logic wr, input logic [3:0] a, input logic [15:0] wd, input bit fe_done);
    logic exp_err; logic [15:0] exp_rd; int exp_pu, exp_po, ws;
    logic [15:0] rd; logic er; int lat, pu, po, viol; logic [7:0] txd;
    ws = (d != 0) ? 3 : 0;
    exp_err = (a > 4'd7) || (wr && (a == 4'd1 || a == 4'd5)) || (wr && a == 4'd0 && tx_full) ||
              (!wr && a == 4'd0 && rx_empty) || (wr && a == 4'd3 && wd == 16'd0) ||
              (wr && a == 4'd2 && wd[4:3] == 2'd3);
    exp_rd = '0;
    if (!wr && !exp_err) begin
      case (a)
        4'd0: exp_rd = {8'h00, rx_data};
        4'd1: exp_rd = {13'd0, rx_empty, tx_full, tx_busy};
        4'd2: exp_rd = {10'd0, ctrl_m[d]};
        4'd3: exp_rd = baud_m[d];
        4'd4: exp_rd = {12'd0, ien_m[d]};
        4'd5: exp_rd = {3'd0, rx_level, 3'd0, tx_level};
        4'd6: exp_rd = {12'd0, stat_m(d)};
        default: exp_rd = {txth_m[d], rxth_m[d]};
      endcase
    end
    exp_pu = (wr && a == 4'd0 && !exp_err) ? 1 : 0;
    exp_po = (!wr && a == 4'd0 && !exp_err) ? 1 : 0;
    xfer(d, wr, a, wd, fe_done, rd, er, lat, pu, po, txd, viol);
    check("pslverr", 32'(er), 32'(exp_err));
    check("prdata", 32'(rd), 32'(exp_rd));
    check("latency", 32'(lat), 32'(ws));
    check("tx_push", 32'(pu), 32'(exp_pu));
    check("rx_pop", 32'(po), 32'(exp_po));
    check("idle_resp", 32'(viol), 32'd0);
    if (exp_pu != 0) check("tx_data", 32'(txd), 32'(wd[7:0]));
    last_rd = rd; last_err = er;
    if (wr && !exp_err) begin
      case (a)
        4'd2: ctrl_m[d] = wd[5:0];
        4'd3: baud_m[d] = wd;
        4'd4: ien_m[d]  = wd[3:0];
        4'd6: begin if (wd[2]) fe_m[d] = 1'b0; if (wd[3]) ov_m[d] = 1'b0; end
        4'd7: begin rxth_m[d] = wd[7:0]; txth_m[d] = wd[15:8]; end
        default: ;
      endcase
    end
    if (fe_done) begin fe_m[0] = 1'b1; fe_m[1] = 1'b1; end
    repeat (2) @(posedge clk); #1;
    check("irq", 32'(irq_w[d]), 32'(|(stat_m(d) & ien_m[d])));
    check("baud_div", 32'(baud_w[d]), 32'(baud_m[d]));
    check("ctrl_out", 32'({stop2_w[d], parity_w[d], data_bits_w[d], uart_en_w[d]}), 32'(ctrl_m[d]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic [3:0] a; logic wr; logic [15:0] wd; int d;
    set_bus(0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0);
    model_reset();
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_pready", 32'(rdy(i)), 32'd0);
      check("rst_prdata", 32'(prd(i)), 32'd0);
      check("rst_pslverr", 32'(perr(i)), 32'd0);
      check("rst_strobes", 32'({tx_push_w[i], rx_pop_w[i]}), 32'd0);
      check("rst_irq", 32'(irq_w[i]), 32'd0);
      check("rst_baud", 32'(baud_w[i]), 32'd27);
      check("rst_ctrl", 32'({stop2_w[i], parity_w[i], data_bits_w[i], uart_en_w[i]}), 32'h06);
    end

    tx_full = 1'b0;
    run(0, 1'b1, 4'd0, 16'h0041, 0);
    run(1, 1'b0, 4'd2, 16'h0000, 0);
    check("ctrl_ws3", 32'(last_rd), 32'h0006);
    rx_empty = 1'b1;
    run(0, 1'b0, 4'd0, 16'h0000, 0);
    check("rx_empty_err", 32'(last_err), 32'd1);
    rx_empty = 1'b0; rx_data = 8'h5A;
    run(0, 1'b0, 4'd0, 16'h0000, 0);
    check("rx_data", 32'(last_rd), 32'h005A);
    run(0, 1'b1, 4'd3, 16'd0, 0);
    check("baud_keep", 32'(baud_w[0]), 32'd27);
    run(0, 1'b1, 4'd3, 16'd54, 0);
    check("baud_54", 32'(baud_w[0]), 32'd54);

    run(0, 1'b1, 4'd4, 16'h0004, 0);
    rx_frame_err = 1'b1;
    @(negedge clk);
    check("irq_pre", 32'(irq_w[0]), 32'd0);
    @(posedge clk); #1;
    rx_frame_err = 1'b0;
    fe_m[0] = 1'b1; fe_m[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("irq_fe", 32'(irq_w[0]), 32'd1);
    run(0, 1'b1, 4'd6, 16'h0004, 1);
    run(0, 1'b0, 4'd6, 16'h0000, 0);
    check("fe_set_wins", 32'(last_rd[2]), 32'd1);
    run(0, 1'b1, 4'd6, 16'h0004, 0);
    run(0, 1'b0, 4'd6, 16'h0000, 0);
    check("fe_cleared", 32'(last_rd[2]), 32'd0);

    // Abort: PSELx dropped during the wait phase.
    @(posedge clk); #1; set_bus(1, 1'b1, 1'b0, 1'b1, 4'd3, 16'd99);
    @(posedge clk); #1; set_bus(1, 1'b1, 1'b1, 1'b1, 4'd3, 16'd99);
    @(posedge clk); #1; set_bus(1, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0);
    cnt = 0;
    repeat (6) begin @(negedge clk); if (bus_b.PREADY) cnt++; end
    check("abort_pready", 32'(cnt), 32'd0);
    check("abort_baud", 32'(baud_w[1]), 32'(baud_m[1]));

    for (int i = 0; i < 90; i++) begin
      d = ($urandom_range(0, 3) == 0) ? 1 : 0;
      tx_full = 1'($urandom_range(0, 1)); tx_busy = 1'($urandom_range(0, 1));
      rx_empty = 1'($urandom_range(0, 1)); rx_data = 8'($urandom);
      tx_level = 5'($urandom_range(0, 16)); rx_level = 5'($urandom_range(0, 16));
      if ($urandom_range(0, 5) == 0) begin
        rx_frame_err = 1'($urandom_range(0, 1)); rx_overrun = ~rx_frame_err;
        for (int k = 0; k < 2; k++) begin
          if (rx_frame_err) fe_m[k] = 1'b1;
          if (rx_overrun) ov_m[k] = 1'b1;
        end
        @(posedge clk); #1;
        rx_frame_err = 1'b0; rx_overrun = 1'b0;
      end
      a = 4'($urandom_range(0, 9)); wr = 1'($urandom_range(0, 1));
      wd = 16'($urandom);
      if ($urandom_range(0, 3) == 0) wd = 16'd0;
      if (a == 4'd7) wd = {8'($urandom_range(0, 17)), 8'($urandom_range(0, 17))};
      if (a == 4'd6 || a == 4'd4) wd = 16'($urandom_range(0, 15));
      run(d, wr, a, wd, 0);
    end

    // Reset in the middle of a wait-state DATA write must leave no trace.
    tx_full = 1'b0;
    @(posedge clk); #1; set_bus(1, 1'b1, 1'b0, 1'b1, 4'd0, 16'h00AA);
    @(posedge clk); #1; set_bus(1, 1'b1, 1'b1, 1'b1, 4'd0, 16'h00AA);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0; set_bus(1, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0);
    cnt = 0;
    repeat (8) begin @(negedge clk); if (bus_b.PREADY || tx_push_w[1]) cnt++; end
    check("rst_abort", 32'(cnt), 32'd0);
    model_reset();
    run(1, 1'b0, 4'd2, 16'h0000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
